ntt_ctrl: RTL and testbench
===========================

NTT_CTRL -- requirements
Module: ntt_ctrl

Interface
REQ-001 Parameter: FIFO_DEPTH, 8, writeback address FIFO entries (power of two, >=2); bounds outstanding butterflies.
REQ-002 Parameter: N_LOG, 8, log2 coefficient count (256); fixed, no other value supported.
REQ-003 Port: clk  input  1  single clock; all logic on rising edge.
REQ-004 Port: reset  input  1  synchronous, active-high reset.
REQ-005 Port: start  input  1  one-cycle request to run a full NTT; sampled only in IDLE.
REQ-006 Port: busy  output  1  high from the cycle after an accepted start until done.
REQ-007 Port: done  output  1  one-cycle pulse when the last writeback retires.
REQ-008 Port: rd_en / rd_addr_a / rd_addr_b  output  1/8/8  coefficient memory read request and pair addresses.
REQ-009 Port: zeta_idx  output  8  twiddle ROM index, valid with rd_en.
REQ-010 Port: bt_en  output  1  butterfly launch; rd_en delayed one cycle (memory read latency 1).
REQ-011 Port: bt_valid  input  1  butterfly result strobe; latency from bt_en is arbitrary but in order.
REQ-012 Port: wr_en / wr_addr_a / wr_addr_b  output  1/8/8  writeback strobe and addresses for A_out/B_out.
REQ-013 Port: err  output  1  sticky: bt_valid received with zero outstanding butterflies.

Function
REQ-014 FSM states IDLE, ISSUE, DRAIN, DONE; IDLE->ISSUE on start; ISSUE->DRAIN after the 128th butterfly of a stage is issued; DRAIN->ISSUE when outstanding==0 and stage<7 (stage++); DRAIN->DONE when outstanding==0 and stage==7; DONE->IDLE after one cycle (done=1 there).
REQ-015 Forward stage s (0..7): len=128>>s; butterfly i (0..127): g=i>>(7-s), rd_addr_a=g*2*len+(i mod len), rd_addr_b=rd_addr_a+len, zeta_idx=(1<<s)+g.
REQ-016 ISSUE issues one butterfly per cycle (rd_en=1), pushing {rd_addr_a,rd_addr_b} into the FIFO in the same cycle.
REQ-017 Issue stalls (rd_en=0, i held) while outstanding==FIFO_DEPTH, unless a pop occurs that cycle.
REQ-018 On bt_valid: wr_en=1 combinationally with FIFO head addresses, head popped; outstanding decremented.
REQ-019 Simultaneous push and pop: outstanding unchanged; both FIFO pointers advance; wraparound modulo FIFO_DEPTH.
REQ-020 bt_valid with outstanding==0: no pop, wr_en=0, err set; operation otherwise continues.
REQ-021 start while busy is ignored; start and bt_valid in IDLE have no effect beyond REQ-020.
REQ-022 Stage barrier: no read of stage s+1 is issued before all stage-s writebacks retire.
REQ-023 Total per run: exactly 1024 rd_en, 1024 bt_en, 1024 wr_en pulses.

Reset
REQ-024 Reset: state IDLE, stage=0, i=0, FIFO empty, outstanding=0; busy, done, rd_en, bt_en, wr_en, err all 0; addresses and zeta_idx 0.
REQ-025 Reset mid-run discards pending FIFO entries; bt_valid after reset counts toward err.

Configuration
REQ-026 Macro NTT_INTT_EN: when defined, adds input inv (1, sampled with start) and output bt_inv (1, held for the run).
REQ-027 With NTT_INTT_EN and inv=1: stage t (0..7) uses len=1<<t, g=i>>t, same address rule, zeta_idx=(256>>t)-1-g, bt_inv=1.
REQ-028 Without NTT_INTT_EN: ports inv and bt_inv absent; forward only.

Verification
REQ-029 start, stub BT latency 3 -> first rd_en: a=0,b=128,zeta=1; stage-0 last: a=127,b=255,zeta=1; stage-7 first: a=0,b=1,zeta=128; last: a=254,b=255,zeta=255; done once; 1024 wr_en.
REQ-030 Stub latency 20, FIFO_DEPTH=8 -> rd_en stalls at 8 outstanding; wr addresses match issue order; result identical to REQ-029.
REQ-031 start pulsed again while busy -> ignored; exactly one done pulse.
REQ-032 reset asserted at 300th issue -> next cycle all outputs 0, busy=0; fresh start reproduces REQ-029 sequence.
REQ-033 bt_valid pulsed in IDLE -> err=1, wr_en=0; err stays 1 until reset.
REQ-034 NTT_INTT_EN, inv=1 -> first: a=0,b=1,zeta=255,bt_inv=1; stage-7 first: a=0,b=128,zeta=1; done after 1024 writebacks.

Source files
------------

// File: rtl/ntt_ctrl_if.sv
// Start/status, coefficient-memory, twiddle and butterfly bus of ntt_ctrl; master = controller side.
// With NTT_INTT_EN the bus also carries inv (sampled with start) and bt_inv (held for the run).
interface ntt_ctrl_if;
    logic       start;
    logic       busy;
    logic       done;
    logic       rd_en;
    logic [7:0] rd_addr_a;
    logic [7:0] rd_addr_b;
    logic [7:0] zeta_idx;
    logic       bt_en;
    logic       bt_valid;
    logic       wr_en;
    logic [7:0] wr_addr_a;
    logic [7:0] wr_addr_b;
    logic       err;
`ifdef NTT_INTT_EN
    logic       inv;
    logic       bt_inv;
`endif

    modport master (
`ifdef NTT_INTT_EN
        input  inv,
        output bt_inv,
`endif
        input  start,
        input  bt_valid,
        output busy,
        output done,
        output rd_en,
        output rd_addr_a,
        output rd_addr_b,
        output zeta_idx,
        output bt_en,
        output wr_en,
        output wr_addr_a,
        output wr_addr_b,
        output err
    );

    modport slave (
`ifdef NTT_INTT_EN
        output inv,
        input  bt_inv,
`endif
        output start,
        output bt_valid,
        input  busy,
        input  done,
        input  rd_en,
        input  rd_addr_a,
        input  rd_addr_b,
        input  zeta_idx,
        input  bt_en,
        input  wr_en,
        input  wr_addr_a,
        input  wr_addr_b,
        input  err
    );
endinterface

// File: rtl/ntt_ctrl.sv
// NTT address/sequence controller for 256 coefficients; optional inverse NTT under macro NTT_INTT_EN.
// Latency: rd_en -> bt_en 1 cycle, bt_valid -> wr_en combinational, done 2 cycles after the last writeback.
// Backpressure: issue stalls while FIFO_DEPTH butterflies are outstanding unless one retires that cycle.
module ntt_ctrl #(
    parameter int FIFO_DEPTH = 8,
    parameter int N_LOG      = 8
) (
    input  logic       clk,
    input  logic       reset,
    ntt_ctrl_if.master bus
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int OW = PW + 1;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] b;
    } pair_t;

    state_t        state;
    logic [2:0]    stage;
    logic [6:0]    idx;
    logic [OW-1:0] outstanding;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    pair_t         fifo_mem [FIFO_DEPTH];
    logic          busy_q;
    logic          done_q;
    logic          bt_en_q;
    logic          err_q;
`ifdef NTT_INTT_EN
    logic          inv_q;
`endif

    logic          full;
    logic          pop;
    logic          push;
    logic [7:0]    addr_a;
    logic [7:0]    addr_b;
    logic [7:0]    zeta;
    pair_t         head;

    assign head = fifo_mem[rd_ptr];
    assign full = (outstanding == OW'(FIFO_DEPTH));
    assign pop  = bus.bt_valid && (outstanding != '0);
    // A retirement in the same cycle frees the slot the new issue needs.
    assign push = (state == ISSUE) && (!full || pop);

    // Pair addresses: len = 1<<sh, group g = i>>sh, a = g*2*len + (i mod len).
    always_comb begin
        logic [3:0] sh;
        logic [7:0] i8;
        logic [7:0] g;
        logic [7:0] mask;
        logic [8:0] z9;
        i8 = {1'b0, idx};
`ifdef NTT_INTT_EN
        sh = inv_q ? {1'b0, stage} : {1'b0, 3'd7 - stage};
`else
        sh = {1'b0, 3'd7 - stage};
`endif
        mask   = (8'd1 << sh) - 8'd1;
        g      = i8 >> sh;
        addr_a = (g << (sh + 4'd1)) | (i8 & mask);
        addr_b = addr_a + (8'd1 << sh);
        z9     = (9'd256 >> stage) - 9'd1 - {1'b0, g};
`ifdef NTT_INTT_EN
        zeta   = inv_q ? z9[7:0] : ((8'd1 << stage) + g);
`else
        zeta   = (8'd1 << stage) + g;
        z9     = '0;
`endif
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.rd_en     = push;
    assign bus.rd_addr_a = push ? addr_a : 8'd0;
    assign bus.rd_addr_b = push ? addr_b : 8'd0;
    assign bus.zeta_idx  = push ? zeta : 8'd0;
    assign bus.bt_en     = bt_en_q;
    assign bus.wr_en     = pop;
    assign bus.wr_addr_a = pop ? head.a : 8'd0;
    assign bus.wr_addr_b = pop ? head.b : 8'd0;
    assign bus.err       = err_q;
`ifdef NTT_INTT_EN
    assign bus.bt_inv    = inv_q;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            stage       <= '0;
            idx         <= '0;
            outstanding <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            bt_en_q     <= 1'b0;
            err_q       <= 1'b0;
`ifdef NTT_INTT_EN
            inv_q       <= 1'b0;
`endif
        end else begin
            bt_en_q <= push;
            done_q  <= 1'b0;
            if (bus.bt_valid && (outstanding == '0)) begin
                err_q <= 1'b1;
            end
            if (push) begin
                fifo_mem[wr_ptr] <= {addr_a, addr_b};
                wr_ptr           <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   outstanding <= outstanding + OW'(1);
                2'b01:   outstanding <= outstanding - OW'(1);
                default: outstanding <= outstanding;
            endcase

            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state  <= ISSUE;
                        busy_q <= 1'b1;
                        stage  <= '0;
                        idx    <= '0;
`ifdef NTT_INTT_EN
                        inv_q  <= bus.inv;
`endif
                    end
                end
                ISSUE: begin
                    if (push) begin
                        idx <= idx + 7'd1;
                        if (idx == 7'h7f) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    // Stage barrier: next stage reads only after every writeback retired.
                    if (outstanding == '0) begin
                        if (stage == 3'(N_LOG - 1)) begin
                            state  <= DONE;
                            busy_q <= 1'b0;
                            done_q <= 1'b1;
                        end else begin
                            stage <= stage + 3'd1;
                            state <= ISSUE;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ntt_ctrl.sv
// Self-checking bench for ntt_ctrl: in-order butterfly stub, queue scoreboard and arithmetic address model.
module tb_ntt_ctrl;
    localparam int DEPTH = 8;
    localparam int TOTAL = 1024;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    ntt_ctrl_if bus();

    ntt_ctrl #(.FIFO_DEPTH(DEPTH), .N_LOG(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        int a;
        int b;
    } pair_t;

    typedef struct {
        bit inv;
        int k;
        int a;
        int b;
        int z;
    } vec_t;

    int    n_checks = 0;
    int    n_fail   = 0;
    int    cyc      = 0;
    logic  rst_d    = 1'b1;
    logic  start_d  = 1'b0;
    logic  vld_d    = 1'b0;
    logic  inv_d    = 1'b0;
    bit    stub_en  = 1'b1;
    int    lat_lo   = 3;
    int    lat_hi   = 3;
    int    due_q[$];
    int    last_due = 0;
    pair_t scb_q[$];
    int    n_rd = 0, n_bt = 0, n_wr = 0, n_done = 0, max_out = 0;
    bit    prev_rd = 1'b0, err_model = 1'b0, run_inv = 1'b0;
    int    obs_a[TOTAL];
    int    obs_b[TOTAL];
    int    obs_z[TOTAL];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Butterfly k of a run: stage k/128, index k%128.
    function automatic void ref_pair(input bit inv, input int k, output int a, output int b, output int z);
        int s, i, len, g;
        s   = k / 128;
        i   = k % 128;
        len = inv ? (1 << s) : (128 >> s);
        g   = i / len;
        a   = g * 2 * len + i % len;
        b   = a + len;
        z   = inv ? (256 >> s) - 1 - g : (1 << s) + g;
    endfunction

    // One clock: drive inputs and stub #1 after the edge, check outputs at the falling edge.
    task automatic tick();
        int    q0, d, ea, eb, ez;
        pair_t p;
        @(posedge clk);
        cyc++;
        #1;
        reset     = rst_d;
        bus.start = start_d;
`ifdef NTT_INTT_EN
        bus.inv   = inv_d;
`endif
        if (rst_d) begin
            due_q.delete();
            last_due     = 0;
            bus.bt_valid = 1'b0;
        end else begin
            bus.bt_valid = stub_en ? (due_q.size() > 0 && due_q[0] == cyc) : vld_d;
            if (stub_en && bus.bt_valid) void'(due_q.pop_front());
            if (bus.bt_en) begin
                d = cyc + int'($urandom_range(lat_hi, lat_lo));
                if (d <= last_due) d = last_due + 1;
                due_q.push_back(d);
                last_due = d;
            end
        end
        @(negedge clk);
        if (reset) begin
            scb_q.delete();
            n_rd = 0; n_bt = 0; n_wr = 0; n_done = 0; max_out = 0;
            prev_rd = 1'b0; err_model = 1'b0;
        end else begin
            q0 = scb_q.size();
            check("bt_en_follows_rd_en", bus.bt_en, prev_rd);
            check("err_sticky_model", bus.err, err_model);
            check("wr_en_vs_valid", bus.wr_en, bus.bt_valid && q0 > 0);
            if (bus.wr_en && q0 > 0) begin
                p = scb_q.pop_front();
                check("wr_addr_a", bus.wr_addr_a, p.a);
                check("wr_addr_b", bus.wr_addr_b, p.b);
                n_wr++;
            end
            if (bus.rd_en) begin
                check("rd_within_run", n_rd < TOTAL, 1);
                if (n_rd < TOTAL) begin
                    ref_pair(run_inv, n_rd, ea, eb, ez);
                    check("rd_addr_a", bus.rd_addr_a, ea);
                    check("rd_addr_b", bus.rd_addr_b, eb);
                    check("zeta_idx", bus.zeta_idx, ez);
                    check("issue_not_over_depth", (q0 < DEPTH) || bus.wr_en, 1);
                    if (n_rd % 128 == 0) check("stage_barrier", q0, 0);
                    obs_a[n_rd] = bus.rd_addr_a;
                    obs_b[n_rd] = bus.rd_addr_b;
                    obs_z[n_rd] = bus.zeta_idx;
                    scb_q.push_back('{a: bus.rd_addr_a, b: bus.rd_addr_b});
                end
                n_rd++;
            end
            if (bus.bt_en) n_bt++;
            if (bus.done) n_done++;
            if (scb_q.size() > max_out) max_out = scb_q.size();
            prev_rd   = bus.rd_en;
            err_model = err_model | (bus.bt_valid && q0 == 0);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_busy"}, bus.busy, 0);
        check({tag, "_done"}, bus.done, 0);
        check({tag, "_rd_en"}, bus.rd_en, 0);
        check({tag, "_bt_en"}, bus.bt_en, 0);
        check({tag, "_wr_en"}, bus.wr_en, 0);
        check({tag, "_err"}, bus.err, 0);
        check({tag, "_rd_addr_a"}, bus.rd_addr_a, 0);
        check({tag, "_rd_addr_b"}, bus.rd_addr_b, 0);
        check({tag, "_zeta_idx"}, bus.zeta_idx, 0);
        check({tag, "_wr_addr_a"}, bus.wr_addr_a, 0);
        check({tag, "_wr_addr_b"}, bus.wr_addr_b, 0);
    endtask

    task automatic run_ntt(input int lo, input int hi, input bit inv, input bit poke);
        bit seen;
        lat_lo = lo; lat_hi = hi; run_inv = inv; inv_d = inv; stub_en = 1'b1;
        rst_d = 1'b1; tick(); rst_d = 1'b0;
        start_d = 1'b1; tick(); start_d = 1'b0;
        inv_d = ~inv;
        tick();
        check("busy_after_start", bus.busy, 1);
`ifdef NTT_INTT_EN
        check("bt_inv_first", bus.bt_inv, inv);
`endif
        seen = 1'b0;
        for (int n = 0; n < 20000 && !seen; n++) begin
            start_d = poke && ($urandom_range(0, 40) == 0);
            tick();
            if (bus.done) seen = 1'b1;
        end
        start_d = 1'b0;
        check("done_within_budget", seen, 1);
        repeat (6) tick();
        check("rd_en_total", n_rd, TOTAL);
        check("bt_en_total", n_bt, TOTAL);
        check("wr_en_total", n_wr, TOTAL);
        check("done_pulses", n_done, 1);
        check("busy_after_done", bus.busy, 0);
        check("err_after_run", bus.err, 0);
`ifdef NTT_INTT_EN
        check("bt_inv_held", bus.bt_inv, inv);
`endif
    endtask

    task automatic check_table(input vec_t tbl[$], input bit inv);
        foreach (tbl[j]) begin
            if (tbl[j].inv == inv) begin
                check($sformatf("tbl%0d_a", tbl[j].k), obs_a[tbl[j].k], tbl[j].a);
                check($sformatf("tbl%0d_b", tbl[j].k), obs_b[tbl[j].k], tbl[j].b);
                check($sformatf("tbl%0d_z", tbl[j].k), obs_z[tbl[j].k], tbl[j].z);
            end
        end
    endtask

    initial begin
        vec_t tbl[$];
        int   n;
        tbl.push_back('{0, 0,    0,   128, 1});
        tbl.push_back('{0, 127,  127, 255, 1});
        tbl.push_back('{0, 128,  0,   64,  2});
        tbl.push_back('{0, 192,  128, 192, 3});
        tbl.push_back('{0, 896,  0,   1,   128});
        tbl.push_back('{0, 1023, 254, 255, 255});
        tbl.push_back('{1, 0,    0,   1,   255});
        tbl.push_back('{1, 1,    2,   3,   254});
        tbl.push_back('{1, 896,  0,   128, 1});
        tbl.push_back('{1, 1023, 127, 255, 1});

        bus.start = 1'b0;
        bus.bt_valid = 1'b0;
`ifdef NTT_INTT_EN
        bus.inv = 1'b0;
`endif
        rst_d = 1'b1; repeat (3) tick(); rst_d = 1'b0; tick();
        check_idle_outputs("reset");

        run_ntt(3, 3, 1'b0, 1'b0);
        check_table(tbl, 1'b0);

        run_ntt(20, 20, 1'b0, 1'b0);
        check("max_outstanding", max_out, DEPTH);
        check_table(tbl, 1'b0);

        run_ntt(1, 25, 1'b0, 1'b1);
        check_table(tbl, 1'b0);

        // Reset right after the 300th issue of a run.
        lat_lo = 3; lat_hi = 3; run_inv = 1'b0;
        rst_d = 1'b1; tick(); rst_d = 1'b0;
        start_d = 1'b1; tick(); start_d = 1'b0;
        n = 0;
        while (n_rd < 300 && n < 5000) begin
            tick();
            n++;
        end
        check("reached_300_issues", n_rd, 300);
        rst_d = 1'b1; tick(); tick();
        check_idle_outputs("midrun_reset");
        rst_d = 1'b0;
        run_ntt(3, 3, 1'b0, 1'b0);
        check_table(tbl, 1'b0);

        // bt_valid with nothing outstanding.
        rst_d = 1'b1; tick(); rst_d = 1'b0; tick();
        stub_en = 1'b0; vld_d = 1'b1; tick();
        check("wr_en_on_idle_valid", bus.wr_en, 0);
        vld_d = 1'b0; tick();
        check("err_set", bus.err, 1);
        repeat (10) tick();
        check("err_still_set", bus.err, 1);
        rst_d = 1'b1; tick(); rst_d = 1'b0; tick();
        check("err_cleared_by_reset", bus.err, 0);
        stub_en = 1'b1;

`ifdef NTT_INTT_EN
        run_ntt(3, 3, 1'b1, 1'b0);
        check_table(tbl, 1'b1);
        run_ntt(1, 12, 1'b1, 1'b1);
        check_table(tbl, 1'b1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
